// File: rtl/sally_bus_responder_if.sv
// CPU-side handshake bundle between the video DMA controller / CPU phase
// generator and the bus responder.
interface sally_bus_responder_if;
  logic        pclk0;
  logic        pclk1;
  logic        halt_b;
  logic        ready;
  logic        int_b;
  logic        cpu_rw;
  logic        clear_stats;
  logic        cpu_ce;
  logic        halt_unlock;
  logic        cpu_drive_AB;
  logic        nmi_n_out;
  logic        rdy_stall;
  logic [12:0] halt_cycles;

  modport master (
    output pclk0, pclk1, halt_b, ready, int_b, cpu_rw, clear_stats,
    input  cpu_ce, halt_unlock, cpu_drive_AB, nmi_n_out, rdy_stall, halt_cycles
  );

  modport slave (
    input  pclk0, pclk1, halt_b, ready, int_b, cpu_rw, clear_stats,
    output cpu_ce, halt_unlock, cpu_drive_AB, nmi_n_out, rdy_stall, halt_cycles
  );
endinterface

// File: rtl/sally_bus_responder.sv
// CPU bus responder: gates the CPU clock enable for DMA halts and ready
// stalls, stretches the display-list NMI and counts halted CPU cycles.
module sally_bus_responder (
  input  logic                    clk_sys,
  input  logic                    reset,
  sally_bus_responder_if.slave    bus
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_PEND = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;
  localparam logic [1:0] ST_RESUME    = 2'd3;

  localparam logic [12:0] HALT_CYCLES_MAX = 13'h1FFF;

  logic [1:0]  state_reg, state_next;
  logic        cpu_ce_reg, cpu_ce_next;
  logic        rdy_stall_reg, rdy_stall_next;
  logic [12:0] halt_cycles_reg, halt_cycles_next;
  logic        int_b_prev_reg;
  logic        nmi_pending_reg, nmi_pending_next;
  logic        nmi_ce_seen_reg, nmi_ce_seen_next;

  logic phase0;
  logic phase1;
  logic int_fall;

  // A coincident pclk1 is dropped so the phase-0 decision is the only one made.
  assign phase0   = bus.pclk0;
  assign phase1   = bus.pclk1 & ~bus.pclk0;
  assign int_fall = int_b_prev_reg & ~bus.int_b;

  always_comb begin
    state_next     = state_reg;
    rdy_stall_next = rdy_stall_reg;
    case (state_reg)
      ST_RUN: begin
        if (phase0 && !bus.halt_b)
          state_next = bus.cpu_rw ? ST_HALTED : ST_HALT_PEND;
      end
      ST_HALT_PEND: begin
        if (phase0) begin
          if (bus.cpu_rw)
            state_next = ST_HALTED;
          else if (bus.halt_b)
            state_next = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (phase0 && bus.halt_b)
          state_next = ST_RESUME;
      end
      ST_RESUME: begin
        if (phase1)
          state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase

    if (phase0) begin
      if (state_reg == ST_RUN && !bus.ready && bus.cpu_rw)
        rdy_stall_next = 1'b1;
      else if (bus.ready)
        rdy_stall_next = 1'b0;
    end
    // Entering a halt overrides any ready stall, which gives halt priority.
    if (state_next == ST_HALTED)
      rdy_stall_next = 1'b0;
  end

  always_comb begin
    cpu_ce_next = phase1 && !rdy_stall_reg &&
                  (state_reg == ST_RUN || state_reg == ST_HALT_PEND);
  end

  // NMI stays low across two delivered cpu_ce pulses; edges are ignored
  // while one is already pending or being driven.
  always_comb begin
    nmi_pending_next = nmi_pending_reg;
    nmi_ce_seen_next = nmi_ce_seen_reg;
    if (!nmi_pending_reg) begin
      if (int_fall) begin
        nmi_pending_next = 1'b1;
        nmi_ce_seen_next = 1'b0;
      end
    end else if (state_reg != ST_HALTED && cpu_ce_reg) begin
      if (nmi_ce_seen_reg) begin
        nmi_pending_next = 1'b0;
        nmi_ce_seen_next = 1'b0;
      end else begin
        nmi_ce_seen_next = 1'b1;
      end
    end
  end

  always_comb begin
    halt_cycles_next = halt_cycles_reg;
    if (bus.clear_stats)
      halt_cycles_next = '0;
    else if (phase0 && state_reg == ST_HALTED && halt_cycles_reg != HALT_CYCLES_MAX)
      halt_cycles_next = halt_cycles_reg + 13'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      cpu_ce_reg      <= 1'b0;
      rdy_stall_reg   <= 1'b0;
      halt_cycles_reg <= '0;
      int_b_prev_reg  <= 1'b1;
      nmi_pending_reg <= 1'b0;
      nmi_ce_seen_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cpu_ce_reg      <= cpu_ce_next;
      rdy_stall_reg   <= rdy_stall_next;
      halt_cycles_reg <= halt_cycles_next;
      int_b_prev_reg  <= bus.int_b;
      nmi_pending_reg <= nmi_pending_next;
      nmi_ce_seen_reg <= nmi_ce_seen_next;
    end
  end

  assign bus.cpu_ce       = cpu_ce_reg;
  assign bus.halt_unlock  = (state_reg == ST_HALTED);
  assign bus.cpu_drive_AB = (state_reg != ST_HALTED);
  assign bus.nmi_n_out    = ~(nmi_pending_reg && state_reg != ST_HALTED);
  assign bus.rdy_stall    = rdy_stall_reg;
  assign bus.halt_cycles  = halt_cycles_reg;

endmodule

// File: tb/tb_sally_bus_responder.sv
// Self-checking bench for sally_bus_responder: per-CPU-cycle cpu_ce
// expectations go through a scoreboard queue, the rest is checked inline.
module tb_sally_bus_responder;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  sally_bus_responder_if bus();

  sally_bus_responder dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_q[$];
  int ce_cnt = 0;
  int nmi_ce_cnt = 0;
  logic last_unlock, last_drive, last_stall, last_nmi;

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (bus.cpu_ce) ce_cnt++;
    if (bus.cpu_ce && !bus.nmi_n_out) nmi_ce_cnt++;
  endtask

  // One CPU cycle: pclk0 pulse, two idle clocks, pclk1 pulse; the
  // expected cpu_ce pulse count is queued when stimulus is driven.
  task automatic cpu_cycle(input logic rw, input logic hb, input logic rdy,
                           input int exp_ce, input string tag);
    int exp;
    exp_q.push_back(exp_ce);
    bus.cpu_rw = rw; bus.halt_b = hb; bus.ready = rdy;
    bus.pclk0  = 1'b1;
    ce_cnt     = 0;
    tick();
    bus.pclk0 = 1'b0;
    last_unlock = bus.halt_unlock;
    last_drive  = bus.cpu_drive_AB;
    last_stall  = bus.rdy_stall;
    last_nmi    = bus.nmi_n_out;
    tick();
    tick();
    bus.pclk1 = 1'b1;
    tick();
    bus.pclk1 = 1'b0;
    exp = exp_q.pop_front();
    n_vec++;
    if (ce_cnt !== exp) begin
      n_miss++;
      $display("FAIL %s cpu_ce pulses: got %0d expected %0d", tag, ce_cnt, exp);
    end else begin
      $display("cycle %s rw=%0b halt_b=%0b ready=%0b ce=%0d unlock=%0b stall=%0b",
               tag, rw, hb, rdy, ce_cnt, last_unlock, last_stall);
    end
  endtask

  task automatic test_reset();
    bus.pclk0 = 1'b1; bus.pclk1 = 1'b1; bus.halt_b = 1'b0; bus.ready = 1'b0;
    bus.cpu_rw = 1'b1; bus.clear_stats = 1'b0; bus.int_b = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.int_b = i[0];
      tick();
    end
    n_vec++;
    if (bus.cpu_ce !== 1'b0 || bus.halt_unlock !== 1'b0 || bus.cpu_drive_AB !== 1'b1 ||
        bus.nmi_n_out !== 1'b1 || bus.rdy_stall !== 1'b0 || bus.halt_cycles !== 13'd0) begin
      n_miss++;
      $display("FAIL reset_state: ce=%0b unlock=%0b drive=%0b nmi=%0b stall=%0b hc=%0d required 0 0 1 1 0 0",
               bus.cpu_ce, bus.halt_unlock, bus.cpu_drive_AB, bus.nmi_n_out, bus.rdy_stall, bus.halt_cycles);
    end
    bus.pclk0 = 1'b0; bus.pclk1 = 1'b0; bus.halt_b = 1'b1; bus.ready = 1'b1; bus.int_b = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (bus.nmi_n_out !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_release_nmi: got %0b required 1", bus.nmi_n_out);
    end
    $display("reset done");
  endtask

  task automatic test_read_halt();
    cpu_cycle(1, 1, 1, 1, "rh_run");
    cpu_cycle(1, 0, 1, 0, "rh_halt");
    n_vec++;
    if (last_unlock !== 1'b1 || last_drive !== 1'b0) begin
      n_miss++;
      $display("FAIL rh_enter: unlock=%0b drive=%0b required 1 0", last_unlock, last_drive);
    end
    cpu_cycle(1, 0, 1, 0, "rh_hold");
    cpu_cycle(1, 1, 1, 0, "rh_resume");
    n_vec++;
    if (last_unlock !== 1'b0 || last_drive !== 1'b1) begin
      n_miss++;
      $display("FAIL rh_resume: unlock=%0b drive=%0b required 0 1", last_unlock, last_drive);
    end
    cpu_cycle(1, 1, 1, 1, "rh_run2");
    n_vec++;
    if (bus.halt_cycles !== 13'd2) begin
      n_miss++;
      $display("FAIL rh_halt_cycles: got %0d required 2", bus.halt_cycles);
    end
  endtask

  task automatic test_write_defer();
    cpu_cycle(0, 0, 1, 1, "wd_pend");
    n_vec++;
    if (last_unlock !== 1'b0) begin
      n_miss++;
      $display("FAIL wd_pend_unlock: got %0b required 0", last_unlock);
    end
    cpu_cycle(0, 0, 1, 1, "wd_pend2");
    cpu_cycle(1, 0, 1, 0, "wd_halt");
    n_vec++;
    if (last_unlock !== 1'b1) begin
      n_miss++;
      $display("FAIL wd_halt_unlock: got %0b required 1", last_unlock);
    end
    cpu_cycle(1, 1, 1, 0, "wd_resume");
    cpu_cycle(1, 1, 1, 1, "wd_run");
    cpu_cycle(0, 0, 1, 1, "wd_pend3");
    cpu_cycle(0, 1, 1, 1, "wd_back");
    cpu_cycle(1, 1, 1, 1, "wd_run2");
    n_vec++;
    if (last_unlock !== 1'b0) begin
      n_miss++;
      $display("FAIL wd_back_run: unlock=%0b required 0", last_unlock);
    end
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 3; i++) begin
      cpu_cycle(1, 1, 0, 0, "rs_read");
      n_vec++;
      if (last_stall !== 1'b1) begin
        n_miss++;
        $display("FAIL rs_stall_set%0d: got %0b required 1", i, last_stall);
      end
    end
    cpu_cycle(1, 1, 1, 1, "rs_clear");
    n_vec++;
    if (last_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rs_stall_clear: got %0b required 0", last_stall);
    end
    for (int i = 0; i < 3; i++) cpu_cycle(0, 1, 0, 1, "rs_write");
    n_vec++;
    if (bus.rdy_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rs_write_ignored: stall=%0b required 0", bus.rdy_stall);
    end
    cpu_cycle(1, 0, 0, 0, "rs_prio");
    n_vec++;
    if (last_unlock !== 1'b1 || last_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rs_halt_priority: unlock=%0b stall=%0b required 1 0", last_unlock, last_stall);
    end
    cpu_cycle(1, 1, 1, 0, "rs_resume");
    cpu_cycle(1, 1, 1, 1, "rs_run");
    cpu_cycle(1, 1, 0, 0, "rs_stall");
    cpu_cycle(1, 0, 0, 0, "rs_halt_clr");
    n_vec++;
    if (last_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL rs_halt_clears_stall: got %0b required 0", last_stall);
    end
    cpu_cycle(1, 1, 1, 0, "rs_resume2");
    cpu_cycle(1, 1, 1, 1, "rs_run2");
  endtask

  task automatic test_nmi();
    nmi_ce_cnt = 0;
    bus.int_b = 1'b0;
    tick();
    n_vec++;
    if (bus.nmi_n_out !== 1'b0) begin
      n_miss++;
      $display("FAIL nmi_assert: got %0b required 0", bus.nmi_n_out);
    end
    cpu_cycle(1, 1, 1, 1, "nmi_c1");
    bus.int_b = 1'b1;
    tick();
    bus.int_b = 1'b0;
    tick();
    cpu_cycle(1, 1, 1, 1, "nmi_c2");
    cpu_cycle(1, 1, 1, 1, "nmi_c3");
    cpu_cycle(1, 1, 1, 1, "nmi_c4");
    n_vec++;
    if (nmi_ce_cnt !== 2 || bus.nmi_n_out !== 1'b1) begin
      n_miss++;
      $display("FAIL nmi_width: ce under nmi=%0d nmi=%0b required 2 1", nmi_ce_cnt, bus.nmi_n_out);
    end
    bus.int_b = 1'b1;
    tick();
    cpu_cycle(1, 0, 1, 0, "nmi_halt");
    bus.int_b = 1'b0;
    tick();
    n_vec++;
    if (bus.nmi_n_out !== 1'b1) begin
      n_miss++;
      $display("FAIL nmi_held_in_halt: got %0b required 1", bus.nmi_n_out);
    end
    bus.int_b = 1'b1;
    cpu_cycle(1, 0, 1, 0, "nmi_halt2");
    n_vec++;
    if (last_nmi !== 1'b1) begin
      n_miss++;
      $display("FAIL nmi_still_held: got %0b required 1", last_nmi);
    end
    nmi_ce_cnt = 0;
    cpu_cycle(1, 1, 1, 0, "nmi_resume");
    n_vec++;
    if (last_nmi !== 1'b0) begin
      n_miss++;
      $display("FAIL nmi_after_resume: got %0b required 0", last_nmi);
    end
    for (int i = 0; i < 3; i++) cpu_cycle(1, 1, 1, 1, "nmi_run");
    n_vec++;
    if (nmi_ce_cnt !== 2 || bus.nmi_n_out !== 1'b1) begin
      n_miss++;
      $display("FAIL nmi_deferred_width: ce under nmi=%0d nmi=%0b required 2 1", nmi_ce_cnt, bus.nmi_n_out);
    end
  endtask

  task automatic test_coincident();
    bus.cpu_rw = 1'b1; bus.halt_b = 1'b1; bus.ready = 1'b1;
    bus.pclk0 = 1'b1; bus.pclk1 = 1'b1;
    ce_cnt = 0;
    tick();
    bus.pclk0 = 1'b0; bus.pclk1 = 1'b0;
    tick();
    tick();
    n_vec++;
    if (ce_cnt !== 0) begin
      n_miss++;
      $display("FAIL coincident_ce: got %0d required 0", ce_cnt);
    end
    bus.halt_b = 1'b0;
    bus.pclk0 = 1'b1; bus.pclk1 = 1'b1;
    tick();
    bus.pclk0 = 1'b0; bus.pclk1 = 1'b0;
    n_vec++;
    if (bus.halt_unlock !== 1'b1) begin
      n_miss++;
      $display("FAIL coincident_halt: unlock=%0b required 1", bus.halt_unlock);
    end
    $display("coincident pclk0/pclk1 done");
    cpu_cycle(1, 1, 1, 0, "co_resume");
    cpu_cycle(1, 1, 1, 1, "co_run");
  endtask

  task automatic test_counter();
    bus.clear_stats = 1'b1;
    tick();
    bus.clear_stats = 1'b0;
    n_vec++;
    if (bus.halt_cycles !== 13'd0) begin
      n_miss++;
      $display("FAIL cnt_clear: got %0d required 0", bus.halt_cycles);
    end
    cpu_cycle(1, 0, 1, 0, "cnt_halt");
    for (int i = 0; i < 8190; i++) begin
      bus.pclk0 = 1'b1; tick(); bus.pclk0 = 1'b0; tick();
    end
    n_vec++;
    if (bus.halt_cycles !== 13'd8190) begin
      n_miss++;
      $display("FAIL cnt_8190: got %0d required 8190", bus.halt_cycles);
    end
    for (int i = 0; i < 10; i++) begin
      bus.pclk0 = 1'b1; tick(); bus.pclk0 = 1'b0; tick();
    end
    n_vec++;
    if (bus.halt_cycles !== 13'd8191) begin
      n_miss++;
      $display("FAIL cnt_saturate: got %0d required 8191", bus.halt_cycles);
    end
    bus.clear_stats = 1'b1; bus.pclk0 = 1'b1;
    tick();
    bus.clear_stats = 1'b0; bus.pclk0 = 1'b0;
    n_vec++;
    if (bus.halt_cycles !== 13'd0) begin
      n_miss++;
      $display("FAIL cnt_clear_wins: got %0d required 0", bus.halt_cycles);
    end
    bus.pclk0 = 1'b1; tick(); bus.pclk0 = 1'b0; tick();
    n_vec++;
    if (bus.halt_cycles !== 13'd1) begin
      n_miss++;
      $display("FAIL cnt_after_clear: got %0d required 1", bus.halt_cycles);
    end
    $display("counter sequence done halt_cycles=%0d", bus.halt_cycles);
  endtask

  task automatic test_reset_mid_halt();
    n_vec++;
    if (bus.halt_unlock !== 1'b1) begin
      n_miss++;
      $display("FAIL rmh_precondition: unlock=%0b required 1", bus.halt_unlock);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if (bus.halt_unlock !== 1'b0 || bus.cpu_drive_AB !== 1'b1 || bus.halt_cycles !== 13'd0 ||
        bus.cpu_ce !== 1'b0) begin
      n_miss++;
      $display("FAIL rmh_state: unlock=%0b drive=%0b hc=%0d ce=%0b required 0 1 0 0",
               bus.halt_unlock, bus.cpu_drive_AB, bus.halt_cycles, bus.cpu_ce);
    end
    reset = 1'b0;
    tick();
    cpu_cycle(1, 1, 1, 1, "rmh_run");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.pclk0 = 1'b0; bus.pclk1 = 1'b0; bus.halt_b = 1'b1; bus.ready = 1'b1;
    bus.int_b = 1'b1; bus.cpu_rw = 1'b1; bus.clear_stats = 1'b0;
    test_reset();
    test_read_halt();
    test_write_defer();
    test_ready_stall();
    test_nmi();
    test_coincident();
    test_counter();
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sally_bus_responder.md
SALLY_BUS_RESPONDER -- requirements
Module: sally_bus_responder

Interface
REQ-001 clk_sys  in  1  system clock; all logic is clocked on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset; clock clk_sys.
REQ-003 pclk0  in  1  one-clk_sys pulse marking the start of CPU phase 0; halt_b, ready and cpu_rw are sampled on it.
REQ-004 pclk1  in  1  one-clk_sys pulse marking the end of the CPU cycle; the CPU advances on it.
REQ-005 halt_b  in  1  active-low halt request from the video DMA controller.
REQ-006 ready  in  1  active-high ready from the video DMA controller; low stalls CPU read cycles.
REQ-007 int_b  in  1  active-low interrupt (display-list interrupt) from the video DMA controller.
REQ-008 cpu_rw  in  1  current CPU cycle direction: 1 = read, 0 = write.
REQ-009 clear_stats  in  1  synchronous clear of halt_cycles.
REQ-010 cpu_ce  out  1  one-clk_sys clock-enable pulse to the CPU core.
REQ-011 halt_unlock  out  1  high while the CPU is halted; the DMA controller may then own the bus.
REQ-012 cpu_drive_AB  out  1  high when the CPU drives the address bus.
REQ-013 nmi_n_out  out  1  stretched active-low NMI to the CPU core.
REQ-014 rdy_stall  out  1  high while a ready stall suppresses cpu_ce.
REQ-015 halt_cycles  out  13  count of pclk0 pulses spent in HALTED; saturates.

Function
REQ-016 The FSM SHALL have four states: RUN, HALT_PEND, HALTED and RESUME.
REQ-017 In RUN and HALT_PEND, cpu_ce SHALL pulse for exactly one clk_sys cycle in the cycle after each pclk1, unless rdy_stall is set.
REQ-018 In RUN, if halt_b=0 at pclk0 and cpu_rw=1, the FSM SHALL enter HALTED on the next clk_sys cycle.
REQ-019 In RUN, if halt_b=0 at pclk0 and cpu_rw=0, the FSM SHALL enter HALT_PEND, so a write cycle is never halted.
REQ-020 In HALT_PEND, at each pclk0:
- if cpu_rw=1, the FSM SHALL enter HALTED;
- if halt_b has returned to 1, the FSM SHALL return to RUN.
REQ-021 In HALTED:
- cpu_ce SHALL be 0, halt_unlock SHALL be 1 and cpu_drive_AB SHALL be 0;
- halt_unlock SHALL rise in the same cycle the state is entered (registered with the state).
REQ-022 In HALTED, when halt_b=1 is sampled at pclk0, the FSM SHALL enter RESUME.
REQ-023 In RESUME:
- halt_unlock SHALL be 0 and cpu_drive_AB SHALL be 1, with no cpu_ce for the pclk1 that follows;
- on that pclk1 the FSM SHALL go to RUN, so the first cpu_ce comes at the second pclk1 after release.
REQ-024 In RUN, if ready=0 at pclk0 and cpu_rw=1, rdy_stall SHALL set; it SHALL clear at the first pclk0 with ready=1.
REQ-025 ready=0 SHALL be ignored on write cycles (cpu_rw=0).
REQ-026 Halt SHALL take priority over ready when both are asserted at the same pclk0.
REQ-027 On entry to HALTED, rdy_stall SHALL clear.
REQ-028 A falling edge of int_b (previous sample 1, current 0) SHALL set nmi_pending.
REQ-029 While nmi_pending is set and the state is not HALTED, nmi_n_out SHALL be driven 0 and held for exactly 2 cpu_ce pulses, then return to 1 and clear nmi_pending.
REQ-030 An int_b falling edge during HALTED SHALL be latched and delivered after RESUME.
REQ-031 A falling edge while nmi_n_out=0 SHALL be ignored (no retrigger, no queue).
REQ-032 halt_cycles:
- SHALL increment on each pclk0 while in HALTED;
- SHALL saturate at 8191;
- clear_stats SHALL win over a simultaneous increment.
REQ-033 If pclk0 and pclk1 coincide, pclk0 sampling SHALL be processed and pclk1 SHALL be ignored for that cycle.

Reset
REQ-034 While reset=1, the block SHALL force:
- FSM to RUN; cpu_ce=0, halt_unlock=0, cpu_drive_AB=1;
- nmi_n_out=1, rdy_stall=0, halt_cycles=0;
- nmi_pending=0 and the int_b edge history to 1.
REQ-035 A reset asserted in any state, including HALTED mid-DMA, SHALL take effect on the next clk_sys edge.
REQ-036 Inputs SHALL have no effect while reset=1.

Verification
REQ-037 Read halt:
- stimulus: RUN, cpu_rw=1, halt_b=0 at pclk0;
- response: HALTED and halt_unlock=1 next cycle, no cpu_ce until release;
- then halt_b=1 at pclk0 -> RESUME, one pclk1 with no cpu_ce, cpu_ce on the following pclk1.
REQ-038 Write deferral:
- stimulus: halt_b=0 at pclk0 with cpu_rw=0;
- response: HALT_PEND, one more cpu_ce; next pclk0 with cpu_rw=1 -> HALTED.
REQ-039 Ready stall:
- stimulus: ready=0 for 3 pclk0 periods on reads;
- response: rdy_stall=1, zero cpu_ce pulses;
- the same stimulus with cpu_rw=0 gives 3 cpu_ce pulses.
REQ-040 NMI:
- stimulus: int_b 1->0;
- response: nmi_n_out=0 for exactly 2 cpu_ce pulses;
- a second edge while nmi_n_out=0 produces no extra pulse;
- an edge while HALTED gives nmi_n_out=0 only after RESUME.
REQ-041 Counter: 8200 pclk0 pulses in HALTED -> halt_cycles=8191; clear_stats=1 -> halt_cycles=0 next cycle.
REQ-042 Reset mid-halt: reset=1 in HALTED -> next cycle RUN, halt_unlock=0, cpu_drive_AB=1, halt_cycles=0.
